// File: rtl/kbd_vt52_encoder.sv
// kbd_vt52_encoder
// ----------------
// Buffers single-cycle keyboard key strobes in a small FIFO, expands cursor and
// editing keys into two-byte VT52 escape sequences, and presents the resulting
// byte stream as an AXI-stream source for the UART transmitter.
//
// Ports:
//   clk            single clock (UART-side domain)
//   reset          synchronous, active-high; clears all state including a
//                  partially sent escape sequence
//   kbd_data       key code, valid while kbd_strobe is high
//   kbd_strobe     one-cycle key pulse
//   m_axis_tdata   output byte
//   m_axis_tvalid  output byte valid
//   m_axis_tready  downstream accepts the byte
//   overflow       sticky; a key was dropped because the FIFO was full
//   fifo_level     number of entries currently stored (0..DEPTH)
module kbd_vt52_encoder #(
  parameter int DEPTH    = 16,
  parameter int PTR_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          kbd_data,
  input  logic                kbd_strobe,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                overflow,
  output logic [PTR_BITS:0]   fifo_level
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAIN  = 2'd1,
    ST_ESC    = 2'd2,
    ST_SUFFIX = 2'd3
  } state_e;

  localparam logic [PTR_BITS:0]   LVL_FULL = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS:0]   LVL_ZERO = {(PTR_BITS + 1){1'b0}};
  localparam logic [PTR_BITS:0]   LVL_ONE  = {{PTR_BITS{1'b0}}, 1'b1};
  localparam logic [PTR_BITS-1:0] PTR_ZERO = {PTR_BITS{1'b0}};
  localparam logic [PTR_BITS-1:0] PTR_ONE  = {{(PTR_BITS - 1){1'b0}}, 1'b1};
  localparam logic [7:0]          ESC_BYTE = 8'h1B;

  // Codes 8'h80..8'h85 are the keys that expand to an escape sequence.
  function automatic logic is_mapped(input logic [7:0] c);
    is_mapped = (c >= 8'h80) && (c <= 8'h85);
  endfunction

  // Second byte of the escape sequence for a mapped key.
  function automatic logic [7:0] suffix_of(input logic [7:0] c);
    case (c)
      8'h80:   suffix_of = 8'h41;  // Up
      8'h81:   suffix_of = 8'h42;  // Down
      8'h82:   suffix_of = 8'h43;  // Right
      8'h83:   suffix_of = 8'h44;  // Left
      8'h84:   suffix_of = 8'h48;  // Home
      8'h85:   suffix_of = 8'h4A;  // Clear
      default: suffix_of = 8'h00;
    endcase
  endfunction

  logic [7:0]          mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_BITS:0]   level_q,    level_d;
  logic                overflow_q, overflow_d;
  state_e              state_q,    state_d;
  logic [7:0]          tdata_q,    tdata_d;
  logic                tvalid_q,   tvalid_d;
  logic [7:0]          suffix_q,   suffix_d;

  logic                accept_s;
  logic                pop_s;
  logic                wr_s;
  logic [7:0]          head_s;

  // Handshake, pop and write qualification for this cycle.
  always_comb begin
    head_s   = mem_q[rd_ptr_q];
    accept_s = tvalid_q && m_axis_tready;
    // A pop happens when the output stage is free (IDLE) or is being emptied
    // by a handshake on the last byte of a sequence, so the next key loads
    // back-to-back without a bubble.
    if (level_q != LVL_ZERO) begin
      pop_s = (state_q == ST_IDLE) ||
              (((state_q == ST_PLAIN) || (state_q == ST_SUFFIX)) && accept_s);
    end else begin
      pop_s = 1'b0;
    end
    // A write while full is still accepted if a pop frees a slot this cycle.
    if (kbd_strobe) begin
      wr_s = (level_q != LVL_FULL) || pop_s;
    end else begin
      wr_s = 1'b0;
    end
  end

  // Next-state computation for FIFO bookkeeping and the output FSM.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    suffix_d   = suffix_q;

    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (kbd_strobe && !wr_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_IDLE, ST_PLAIN, ST_SUFFIX: begin
        if (pop_s) begin
          // Load the popped key exactly the same way from every state.
          if (!head_s[7]) begin
            tdata_d  = head_s;
            tvalid_d = 1'b1;
            state_d  = ST_PLAIN;
          end else if (is_mapped(head_s)) begin
            tdata_d  = ESC_BYTE;
            tvalid_d = 1'b1;
            suffix_d = suffix_of(head_s);
            state_d  = ST_ESC;
          end else begin
            // Unmapped high code: consumed silently.
            tvalid_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else if ((state_q != ST_IDLE) && accept_s) begin
          // Last byte taken and nothing queued.
          tvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = state_q;
        end
      end
      ST_ESC: begin
        if (accept_s) begin
          tdata_d  = suffix_q;
          tvalid_d = 1'b1;
          state_d  = ST_SUFFIX;
        end else begin
          state_d  = ST_ESC;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LVL_ZERO;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      suffix_q   <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      suffix_q   <= suffix_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_s && !reset) begin
      mem_q[wr_ptr_q] <= kbd_data;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_kbd_vt52_encoder.sv
module tb_kbd_vt52_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] kbd_data;
  logic       kbd_strobe;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       overflow;
  logic [4:0] fifo_level;

  int total = 0;
  int bad   = 0;

  kbd_vt52_encoder #(.DEPTH(16), .PTR_BITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .kbd_data      (kbd_data),
    .kbd_strobe    (kbd_strobe),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Inputs driven in a cycle; expected outputs observed in that same cycle
  // (i.e. the result of all earlier cycles' inputs).
  typedef struct {
    logic       strb;
    logic [7:0] data;
    logic       rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [4:0] exp_lvl;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic strb, input logic [7:0] data, input logic rdy);
    @(posedge clk);
    #1;
    kbd_strobe    = strb;
    kbd_data      = data;
    m_axis_tready = rdy;
  endtask

  initial begin
    // Test 1: single plain key
    vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    // Test 2: Up then 'a', no bubbles
    vecs[5]  = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'h61, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h1B, 5'd1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h61, 5'd0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    // Test 4: unmapped code dropped
    vecs[11] = '{1'b1, 8'h90, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[12] = '{1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 5'd0, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    // Test 5: Left with backpressure
    vecs[16] = '{1'b1, 8'h83, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1B, 5'd0, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1B, 5'd0, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1B, 5'd0, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1B, 5'd0, 1'b0};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1B, 5'd0, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h1B, 5'd0, 1'b0};
    vecs[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 5'd0, 1'b0};
    vecs[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

    reset         = 1'b1;
    kbd_strobe    = 1'b0;
    kbd_data      = 8'h00;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_tvalid",   {31'd0, m_axis_tvalid}, 32'd0);
    chk("reset_tdata",    {24'd0, m_axis_tdata},  32'h00);
    chk("reset_level",    {27'd0, fifo_level},    32'd0);
    chk("reset_overflow", {31'd0, overflow},      32'd0);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].strb, vecs[i].data, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_tvalid", i), {31'd0, m_axis_tvalid}, {31'd0, vecs[i].exp_v});
      if (vecs[i].exp_v)
        chk($sformatf("vec%0d_tdata", i), {24'd0, m_axis_tdata}, {24'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_level", i), {27'd0, fifo_level}, {27'd0, vecs[i].exp_lvl});
      chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end

    // Test 3: fill to full under backpressure, overflow, then drain in order
    begin
      logic [7:0] b;
      int idx;
      for (int i = 0; i < 17; i++) begin
        b = 8'h30 + 8'(i);
        drive(1'b1, b, 1'b0);
        @(negedge clk);
        if (i == 16) begin
          chk("fill16_level", {27'd0, fifo_level}, 32'd15);
          chk("fill16_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
          chk("fill16_tdata", {24'd0, m_axis_tdata}, 32'h30);
        end
      end
      drive(1'b1, 8'h99, 1'b0);
      @(negedge clk);
      chk("fill17_level", {27'd0, fifo_level}, 32'd16);
      chk("fill17_overflow", {31'd0, overflow}, 32'd0);
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("full_drop_overflow", {31'd0, overflow}, 32'd1);
      chk("full_drop_level", {27'd0, fifo_level}, 32'd16);
      drive(1'b0, 8'h00, 1'b1);
      idx = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (m_axis_tvalid) begin
          b = 8'h30 + 8'(idx);
          chk($sformatf("drain%0d_tdata", idx), {24'd0, m_axis_tdata}, {24'd0, b});
          idx++;
        end
      end
      chk("drain_count", idx, 32'd17);
      chk("drain_overflow_sticky", {31'd0, overflow}, 32'd1);
      chk("drain_level", {27'd0, fifo_level}, 32'd0);
    end

    // Test 6: reset while in SUFFIX with three keys queued
    drive(1'b1, 8'h84, 1'b0);
    drive(1'b1, 8'h61, 1'b0);
    drive(1'b1, 8'h62, 1'b0);
    drive(1'b1, 8'h63, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("pre_esc_tdata", {24'd0, m_axis_tdata}, 32'h1B);
    chk("pre_esc_level", {27'd0, fifo_level}, 32'd3);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("suffix_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("suffix_tdata", {24'd0, m_axis_tdata}, 32'h48);
    chk("suffix_level", {27'd0, fifo_level}, 32'd3);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("midreset_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midreset_tdata", {24'd0, m_axis_tdata}, 32'h00);
    chk("midreset_level", {27'd0, fifo_level}, 32'd0);
    chk("midreset_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d_tvalid", c), {31'd0, m_axis_tvalid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_vt52_encoder.md
Name: kbd_vt52_encoder

Overview:
Sits between the USB keyboard byte interface and the UART transmit AXI-stream input, in the 160 MHz UART clock domain.
- Captures single-cycle keyboard strobes into a small FIFO so back-to-back keys are not lost while the UART is busy.
- Expands special key codes into the two-byte VT52 escape sequences the host expects.
- Presents the result as an AXI-stream byte source.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
PTR_BITS, 4, log2(DEPTH)

Ports:
clk  input  1  single clock (UART-side clock)
reset  input  1  synchronous, active-high
kbd_data  input  8  key code, valid in the cycle kbd_strobe is high
kbd_strobe  input  1  one-cycle pulse, already synchronized and edge-detected upstream
m_axis_tdata  output  8  byte to UART transmitter
m_axis_tvalid  output  1  tdata valid
m_axis_tready  input  1  UART accepts byte
overflow  output  1  sticky; a strobe arrived while the FIFO was full
fifo_level  output  PTR_BITS+1  entries currently stored (0..DEPTH)

Behaviour:
- Reset: clears everything (takes effect on the next clk edge, any state including mid-sequence).
  - Pointers and fifo_level go to 0; overflow=0.
  - m_axis_tvalid=0, m_axis_tdata=8'h00; FSM goes to IDLE.
  - A partially sent escape sequence is abandoned.
- FIFO write:
  - On kbd_strobe with fifo_level<DEPTH, kbd_data is stored at the write pointer at the clock edge; the pointer wraps modulo DEPTH.
  - On kbd_strobe with fifo_level==DEPTH, the byte is dropped and overflow is set to 1. overflow is cleared only by reset.
- FIFO read (pop): happens only in IDLE, or in the final accept cycle of PLAIN/SUFFIX when the FIFO is non-empty.
- Simultaneous write and pop in one cycle: both happen and fifo_level is unchanged. This includes a write while full: if a pop occurs in the same cycle, the write is accepted and no overflow is flagged.
- Code map, applied to a popped byte c:
  - 8'h00-8'h7F: pass through as 1 byte.
  - 8'h80 Up -> 8'h1B 8'h41; 8'h81 Down -> 8'h1B 8'h42; 8'h82 Right -> 8'h1B 8'h43; 8'h83 Left -> 8'h1B 8'h44; 8'h84 Home -> 8'h1B 8'h48; 8'h85 Clear -> 8'h1B 8'h4A.
  - 8'h86-8'hFF: consumed with no output (dropped silently).
- FSM states: IDLE, PLAIN, ESC, SUFFIX.
  - IDLE: if the FIFO is non-empty, pop c.
    - Passthrough: tdata<=c, tvalid<=1, go to PLAIN.
    - Mapped: tdata<=8'h1B, tvalid<=1, latch the suffix byte, go to ESC.
    - Dropped: stay in IDLE, tvalid stays 0.
  - PLAIN / SUFFIX: hold tdata and tvalid until tready. On the accept cycle (tvalid&&tready), load the next FIFO entry directly, exactly as IDLE would, with no bubble. If the FIFO is empty, go to IDLE with tvalid=0.
  - ESC: hold 8'h1B until tready. On accept, tdata<=suffix, go to SUFFIX with tvalid staying 1.
- AXI rules:
  - tdata stays stable while tvalid&&!tready.
  - tvalid never deasserts without a handshake, except on reset.
  - tvalid does not depend combinationally on tready.
- Latency: a strobe in cycle N with the FIFO empty and the FSM in IDLE gives tvalid=1 in cycle N+2 (write edge at end of N, pop/load edge at end of N+1).
- Throughput: one byte per cycle while tready is held high and the FIFO is non-empty.
- An escape sequence is never interleaved with other bytes.

Test Plan:
1. Reset, tready=1, strobe 8'h41 -> tvalid rises 2 cycles after the strobe with tdata=8'h41, one beat only; fifo_level returns to 0; overflow=0.
2. Strobe 8'h80, then 8'h61 on the next cycle, tready=1 -> stream is 8'h1B, 8'h41, 8'h61 on consecutive cycles, with no bubbles between them.
3. tready=0, 17 strobes of 8'h30..8'h40 on consecutive cycles -> fifo_level=15 after 16 strobes (first byte already loaded into the output register) and 16 after the 17th; a further strobe of 8'h99 sets overflow=1. Then tready=1 -> exactly 8'h30..8'h40 appear in order, and overflow stays 1.
4. Strobe 8'h90, then 8'h42, tready=1 -> only 8'h42 is output; 8'h90 produces no tvalid.
5. Strobe 8'h83, tready=0 for 5 cycles -> tdata holds 8'h1B with tvalid=1 throughout; after tready=1, 8'h1B is accepted and then 8'h44 is presented.
6. Reset asserted while in SUFFIX holding 8'h48 with 3 entries queued -> next cycle tvalid=0, fifo_level=0, overflow=0; after release, no stale bytes are output.
